// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU package: memory-port arbiter state encoding and default widths.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_I = 2'd1,
        ST_RD_D = 2'd2
    } arb_state_e;

    // Width of a counter able to hold 0..max_val (never narrower than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// Winner select: data port has priority unless the fetch port is being forced
// through after losing too many consecutive arbitrations.
module arb_prio_sel (
    input  logic i_req,
    input  logic d_req,
    input  logic force_i,
    output logic i_win,
    output logic d_win
);

    // Priority select with starvation override.
    always_comb begin
        i_win = i_req && (force_i || !d_req);
        d_win = d_req && !(force_i && i_req);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with one outstanding
// transaction, starvation protection for fetch and a sticky protocol error flag.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                err_o
);

    localparam int BE_W = DATA_W / 8;
    localparam int WCW  = cnt_width(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);
    localparam logic [WCW-1:0] WAIT_ZERO = WCW'(0);

    arb_state_e     state_r, state_next_s;
    logic [WCW-1:0] wait_cnt_r, wait_cnt_next_s;
    logic           err_r, err_next_s;
    logic           idle_s, force_i_s, i_win_s, d_win_s;

    assign idle_s    = (state_r == ST_IDLE);
    assign force_i_s = (wait_cnt_r == WAIT_MAX);

    arb_prio_sel u_arb_prio_sel (
        .i_req   (i_req),
        .d_req   (d_req),
        .force_i (force_i_s),
        .i_win   (i_win_s),
        .d_win   (d_win_s)
    );

    // Read data is a pure pass-through; the valid pulses qualify it.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign err_o   = err_r;

    // Memory request mux and completion pulses, all forced low during reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = {BE_W{1'b1}};
        mem_addr  = i_addr;
        mem_wdata = {DATA_W{1'b0}};
        i_rvalid  = 1'b0;
        d_done    = 1'b0;
        if (d_win_s) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else begin
            mem_we    = 1'b0;
        end
        if (rst_n) begin
            mem_req  = idle_s && (i_win_s || d_win_s);
            i_rvalid = (state_r == ST_RD_I) && mem_rvalid;
            d_done   = ((state_r == ST_RD_D) && mem_rvalid) ||
                       (idle_s && d_win_s && d_we && mem_gnt);
        end else begin
            mem_req  = 1'b0;
        end
    end

    // Next-state logic: a granted read parks in RD_I/RD_D until its data returns.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_gnt && d_win_s && !d_we) begin
                    state_next_s = ST_RD_D;
                end else if (mem_gnt && i_win_s) begin
                    state_next_s = ST_RD_I;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_I, ST_RD_D: begin
                if (mem_rvalid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Count data grants that overtook a waiting fetch; saturates to force fetch.
    always_comb begin
        wait_cnt_next_s = wait_cnt_r;
        if (!i_req) begin
            wait_cnt_next_s = WAIT_ZERO;
        end else if (idle_s && mem_gnt && i_win_s) begin
            wait_cnt_next_s = WAIT_ZERO;
        end else if (idle_s && mem_gnt && d_win_s && (wait_cnt_r != WAIT_MAX)) begin
            wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_next_s = wait_cnt_r;
        end
    end

    // Protocol errors: unsolicited read data or a grant nobody asked for.
    always_comb begin
        err_next_s = err_r;
        if ((idle_s && mem_rvalid) || (mem_gnt && !mem_req)) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_r;
        end
    end

    // State, starvation counter and error flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= WAIT_ZERO;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            err_r      <= err_next_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; memory side is driven by hand.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req, i_rvalid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req, d_we, d_done;
    logic [BE_W-1:0]   d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid, err_o;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_o(err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (i_rvalid !== 1'b0 || d_done !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", i_rvalid, d_done); end
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        step();
        i_req = 1'b0; rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h0000_0100; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100 || mem_we !== 1'b0 || mem_be !== 4'hF)
            begin n_fail++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b be=%h want 1/00000100/0/f", mem_req, mem_addr, mem_we, mem_be); end
        n_checks++; if (i_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid: got %b want 0", i_rvalid); end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0000_0013)
            begin n_fail++; $display("FAIL fetch_data: got v=%b d=%h want 1/00000013", i_rvalid, i_rdata); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_rd_i_req: got %b want 0", mem_req); end
        step();
        i_req = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (i_rvalid !== 1'b0 || mem_req !== 1'b0 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL fetch_after: got v=%b req=%b err=%b want 000", i_rvalid, mem_req, err_o); end
        step();
    endtask

    task automatic test_write();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b1111; d_addr = 32'h0000_0040;
        d_wdata = 32'hDEAD_BEEF; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_0040 ||
                        mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'hF)
            begin n_fail++; $display("FAIL write_issue: got req=%b we=%b addr=%h wd=%h be=%h", mem_req, mem_we, mem_addr, mem_wdata, mem_be); end
        n_checks++; if (d_done !== 1'b1) begin n_fail++; $display("FAIL write_done: got %b want 1", d_done); end
        step();
        d_req = 1'b0; mem_gnt = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0200;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0200 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL write_stays_idle: got req=%b addr=%h done=%b want 1/00000200/0", mem_req, mem_addr, d_done); end
        step();
        i_req = 1'b0;
        step();
    endtask

    task automatic test_simul_read();
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_addr !== 32'h0000_0080 || mem_we !== 1'b0 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL simul_d_wins: got addr=%h we=%b done=%b want 00000080/0/0", mem_addr, mem_we, d_done); end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_0001 || i_rvalid !== 1'b0 || mem_req !== 1'b0)
            begin n_fail++; $display("FAIL simul_d_data: got done=%b d=%h iv=%b req=%b", d_done, d_rdata, i_rvalid, mem_req); end
        step();
        d_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100)
            begin n_fail++; $display("FAIL simul_i_next: got req=%b addr=%h want 1/00000100", mem_req, mem_addr); end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h0000_0013 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL simul_i_data: got v=%b d=%h done=%b", i_rvalid, i_rdata, d_done); end
        step();
        i_req = 1'b0; mem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int  d_grants = 0;
        bit  seen_i   = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h0000_0040; d_wdata = 32'h1234_5678;
        i_req = 1'b1; i_addr = 32'h0000_0100; mem_gnt = 1'b1;
        for (int c = 0; c < 10 && !seen_i; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h0000_0100 && !mem_we) seen_i = 1'b1;
            else if (d_done) d_grants++;
            if (!seen_i) step();
        end
        n_checks++; if (!seen_i) begin n_fail++; $display("FAIL b2b_i_timeout: fetch not issued within 10 cycles"); end
        n_checks++; if (d_grants !== 4) begin n_fail++; $display("FAIL b2b_d_grants: got %0d want 4", d_grants); end
        n_checks++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL b2b_i_slot_done: got %b want 0", d_done); end
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093;
        @(negedge clk);
        n_checks++; if (i_rvalid !== 1'b1 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL b2b_i_data: got iv=%b done=%b want 1/0", i_rvalid, d_done); end
        step();
        i_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        n_checks++; if (d_done !== 1'b1 || mem_addr !== 32'h0000_0040)
            begin n_fail++; $display("FAIL b2b_d_resume: got done=%b addr=%h want 1/00000040", d_done, mem_addr); end
        step();
        d_req = 1'b0; mem_gnt = 1'b0;
        step();
    endtask

    task automatic test_gnt_stall();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0084; mem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0084 || d_done !== 1'b0)
                begin n_fail++; $display("FAIL stall_cycle%0d: got req=%b addr=%h done=%b", c, mem_req, mem_addr, d_done); end
            step();
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        n_checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0BAD_F00D || err_o !== 1'b0)
            begin n_fail++; $display("FAIL stall_read_done: got done=%b d=%h err=%b", d_done, d_rdata, err_o); end
        step();
        d_req = 1'b0; mem_rvalid = 1'b0;
        step();
    endtask

    task automatic test_error_and_reset();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        n_checks++; if (i_rvalid !== 1'b0 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL err_no_pulse: got iv=%b done=%b want 00", i_rvalid, d_done); end
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err_o); end
        step(); step();
        @(negedge clk);
        n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_o); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0088; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; rst_n = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0 || d_done !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_outputs: got req=%b done=%b want 00", mem_req, d_done); end
        step();
        @(negedge clk);
        n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b want 0", err_o); end
        step();
        rst_n = 1'b1; i_req = 1'b1; i_addr = 32'h0000_0400;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0400)
            begin n_fail++; $display("FAIL rst_mid_idle: got req=%b addr=%h want 1/00000400", mem_req, mem_addr); end
        step();
        i_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_simul_read();
        test_back_to_back();
        test_gnt_stall();
        test_error_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width (byte enables DATA_W/8).
REQ-003 The block SHALL have parameter MAX_WAIT, default 4, meaning consecutive lost arbitration cycles before the fetch port is forced to win.
REQ-004 The block SHALL have these ports:
 clk  in  1  clock.
 rst_n  in  1  reset, synchronous, active-low.
 i_req  in  1  fetch read request, held until i_rvalid.
 i_addr  in  ADDR_W  fetch address, stable while i_req.
 i_rvalid  out  1  fetch data valid, one-cycle pulse.
 i_rdata  out  DATA_W  fetch data.
 d_req  in  1  data request, held until d_done.
 d_we  in  1  1 = write, 0 = read.
 d_be  in  DATA_W/8  write byte enables.
 d_addr  in  ADDR_W  data address, stable while d_req.
 d_wdata  in  DATA_W  write data.
 d_done  out  1  write accepted or read data valid, one-cycle pulse.
 d_rdata  out  DATA_W  data read result.
 mem_req  out  1  memory request.
 mem_we  out  1  memory write.
 mem_be  out  DATA_W/8  memory byte enables.
 mem_addr  out  ADDR_W  memory address.
 mem_wdata  out  DATA_W  memory write data.
 mem_gnt  in  1  memory accepts request this cycle.
 mem_rvalid  in  1  read data valid, at least 1 cycle after grant.
 mem_rdata  in  DATA_W  read data.
 err_o  out  1  sticky protocol error.

Function
REQ-005 The FSM SHALL have states IDLE, RD_I (fetch read outstanding) and RD_D (data read outstanding); at most one transaction outstanding.
REQ-006 In IDLE, the winner SHALL be d when only d_req, i when only i_req, and d when both, unless wait_cnt == MAX_WAIT, in which case i wins.
REQ-007 In IDLE with a winner, mem_req SHALL be 1 combinationally with the winner's addr/we/be/wdata (mem_we = 0, mem_be = all ones for fetch); mem_req SHALL be 0 in RD_I/RD_D and in IDLE with no request.
REQ-008 Arbitration SHALL be re-evaluated every IDLE cycle while mem_gnt = 0; the winner may change between cycles.
REQ-009 On IDLE with mem_gnt = 1: a d write SHALL pulse d_done the same cycle and stay in IDLE; a d read SHALL go to RD_D; an i fetch SHALL go to RD_I.
REQ-010 In RD_I/RD_D, on mem_rvalid = 1, the owner's rvalid/done SHALL pulse that cycle with rdata = mem_rdata (combinational pass-through), and the FSM SHALL return to IDLE; the next request issues no earlier than the following cycle.
REQ-011 i_rdata and d_rdata SHALL equal mem_rdata at all times; only the valid pulses qualify them.
REQ-012 wait_cnt SHALL increment (saturating at MAX_WAIT) each IDLE cycle where i_req = 1 and d wins with mem_gnt = 1, and SHALL clear when an i fetch is granted or i_req = 0.
REQ-013 Minimum read latency SHALL be 2 cycles from request to valid pulse (grant cycle + rvalid cycle); write latency SHALL be 1 cycle.
REQ-014 err_o SHALL set and hold when mem_rvalid = 1 in IDLE or mem_gnt = 1 while mem_req = 0; such rvalid SHALL produce no i_rvalid/d_done.
REQ-015 A requester dropping req before completion is illegal; the block SHALL NOT detect it.

Reset
REQ-016 On rst_n = 0 at a clk edge: state = IDLE, wait_cnt = 0, err_o = 0; mem_req, i_rvalid, d_done SHALL read 0 during reset.
REQ-017 Reset mid-transaction SHALL abandon the outstanding read; memory is reset by the same rst_n, so no late rvalid arrives.

Structure
REQ-018 State encoding (IDLE/RD_I/RD_D) and the default widths SHALL live in the shared CPU package.
REQ-019 The block SHALL be one module with one natural sub-module, arb_prio_sel (priority plus starvation-override select).

Verification
REQ-020 The bench SHALL cover:
 - i fetch only, addr 0x100, mem_gnt immediate, rvalid 1 cycle later with 0x00000013 -> i_rvalid pulse on cycle 2, i_rdata 0x00000013.
 - d write addr 0x40, be 4'b1111, data 0xDEADBEEF, gnt immediate -> mem_we = 1 with those values, d_done the same cycle, state stays IDLE.
 - i and d read simultaneously -> d wins, i issued the cycle after d_done.
 - d_req held continuously (back-to-back writes) with i_req = 1, MAX_WAIT = 4 -> i granted after exactly 4 d grants.
 - mem_gnt low for 3 cycles -> mem_req held with stable addr, no state change.
 - rvalid in IDLE -> err_o = 1 sticky, no valid pulse; rst_n low mid-RD_D -> IDLE, err_o = 0.
